// File: rtl/dma_bus_arbiter.sv
// Bus arbiter / command controller for the 12-word device-to-memory DMA engine.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module dma_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       dma_begin,
  input  logic       BR,
  input  logic       dma_end,
  input  logic       cpu_mem_busy,
  output logic       cmd,
  output logic       BG,
  output logic       cpu_stall,
  output logic [7:0] xfer_count,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_BUS,
    S_GRANT,
    S_RELEASE
  } state_e;

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic       cmd_q, cmd_d;
  logic       bg_q, bg_d;
  logic [7:0] xfer_count_q, xfer_count_d;
  logic       timeout_err_q, timeout_err_d;
  logic       wd_expire;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] grant_cnt_q, grant_cnt_d;

  // Counter sits at zero outside GRANT, so it is clear on GRANT entry.
  always_comb begin
    grant_cnt_d = '0;
    if (state_q == S_GRANT) begin
      grant_cnt_d = grant_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign wd_expire = (state_q == S_GRANT) && (grant_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    xfer_count_d  = xfer_count_q;
    timeout_err_d = 1'b0;

    // One-deep latch: a begin outside IDLE is remembered; extra ones merge.
    if (state_q != S_IDLE && dma_begin) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dma_begin || pending_q) begin
          state_d   = S_CMD;
          pending_d = 1'b0;
        end
      end
      S_CMD: begin
        if (BR) begin
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!cpu_mem_busy) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A completion on the timeout edge wins over the watchdog.
        if (dma_end) begin
          state_d      = S_RELEASE;
          xfer_count_d = xfer_count_q + 8'd1;
        end else if (wd_expire) begin
          state_d       = S_RELEASE;
          timeout_err_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!BR) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered decodes of the next state keep inputs off the output path.
    cmd_d = (state_d == S_CMD) || (state_d == S_WAIT_BUS) || (state_d == S_GRANT);
    bg_d  = (state_d == S_GRANT);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      cmd_q         <= 1'b0;
      bg_q          <= 1'b0;
      xfer_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cmd_q         <= cmd_d;
      bg_q          <= bg_d;
      xfer_count_q  <= xfer_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd         = cmd_q;
  assign BG          = bg_q;
  assign cpu_stall   = (state_q == S_WAIT_BUS) || (state_q == S_GRANT) || (state_q == S_RELEASE);
  assign xfer_count  = xfer_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter.
module tb_dma_bus_arbiter;

  logic       CLK;
  logic       reset_n;
  logic       dma_begin;
  logic       BR;
  logic       dma_end;
  logic       cpu_mem_busy;
  logic       cmd;
  logic       BG;
  logic       cpu_stall;
  logic [7:0] xfer_count;
  logic       timeout_err;

  int n_checks;
  int n_fail;

  dma_bus_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .dma_begin   (dma_begin),
    .BR          (BR),
    .dma_end     (dma_end),
    .cpu_mem_busy(cpu_mem_busy),
    .cmd         (cmd),
    .BG          (BG),
    .cpu_stall   (cpu_stall),
    .xfer_count  (xfer_count),
    .timeout_err (timeout_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    dma_begin    = 1'b0;
    BR           = 1'b0;
    dma_end      = 1'b0;
    cpu_mem_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cmd, BG, cpu_stall, timeout_err} !== 4'b0000) begin
      $display("FAIL reset_outputs: got %b expected 0000", {cmd, BG, cpu_stall, timeout_err});
      n_fail++;
    end
    n_checks++;
    if (xfer_count !== 8'd0) begin
      $display("FAIL reset_count: got %0d expected 0", xfer_count);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    n_checks++;
    if ({cmd, BG, cpu_stall} !== 3'b100) begin
      $display("FAIL basic_cmd: got %b expected 100", {cmd, BG, cpu_stall});
      n_fail++;
    end
    BR = 1'b1;
    tick();
    n_checks++;
    if ({cmd, BG, cpu_stall} !== 3'b101) begin
      $display("FAIL basic_wait_bus: got %b expected 101", {cmd, BG, cpu_stall});
      n_fail++;
    end
    tick();
    n_checks++;
    if ({cmd, BG, cpu_stall} !== 3'b111) begin
      $display("FAIL basic_grant: got %b expected 111", {cmd, BG, cpu_stall});
      n_fail++;
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if (BG !== 1'b1) begin
        $display("FAIL basic_grant_hold: cycle %0d got %b expected 1", i, BG);
        n_fail++;
      end
    end
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    n_checks++;
    if ({cmd, BG, cpu_stall, xfer_count} !== {3'b001, 8'd1}) begin
      $display("FAIL basic_release: got %b/%0d expected 001/1", {cmd, BG, cpu_stall}, xfer_count);
      n_fail++;
    end
    BR = 1'b0;
    tick();
    n_checks++;
    if ({cmd, BG, cpu_stall} !== 3'b000) begin
      $display("FAIL basic_idle: got %b expected 000", {cmd, BG, cpu_stall});
      n_fail++;
    end
  endtask

  task automatic test_cpu_busy();
    do_reset();
    dma_begin = 1'b1;
    tick();
    dma_begin    = 1'b0;
    BR           = 1'b1;
    cpu_mem_busy = 1'b1;
    tick();
    n_checks++;
    if ({BG, cpu_stall} !== 2'b01) begin
      $display("FAIL busy_wait_entry: got %b expected 01", {BG, cpu_stall});
      n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({cmd, BG, cpu_stall} !== 3'b101) begin
        $display("FAIL busy_hold: cycle %0d got %b expected 101", i, {cmd, BG, cpu_stall});
        n_fail++;
      end
    end
    cpu_mem_busy = 1'b0;
    tick();
    n_checks++;
    if (BG !== 1'b1) begin
      $display("FAIL busy_grant: got %b expected 1", BG);
      n_fail++;
    end
    // CPU traffic and BR drop inside GRANT are ignored.
    cpu_mem_busy = 1'b1;
    BR           = 1'b0;
    tick();
    cpu_mem_busy = 1'b0;
    n_checks++;
    if (BG !== 1'b1) begin
      $display("FAIL busy_ignored_in_grant: got %b expected 1", BG);
      n_fail++;
    end
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    tick();
    n_checks++;
    if ({cmd, BG, cpu_stall, xfer_count} !== {3'b000, 8'd1}) begin
      $display("FAIL busy_done: got %b/%0d expected 000/1", {cmd, BG, cpu_stall}, xfer_count);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    BR        = 1'b1;
    tick();
    tick();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    tick();
    dma_begin = 1'b1;
    dma_end   = 1'b1;
    tick();
    dma_begin = 1'b0;
    dma_end   = 1'b0;
    n_checks++;
    if ({cmd, BG, xfer_count} !== {2'b00, 8'd1}) begin
      $display("FAIL b2b_first_done: got %b/%0d expected 00/1", {cmd, BG}, xfer_count);
      n_fail++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({cmd, cpu_stall} !== 2'b01) begin
        $display("FAIL b2b_release_hold: cycle %0d got %b expected 01", i, {cmd, cpu_stall});
        n_fail++;
      end
    end
    BR = 1'b0;
    tick();
    n_checks++;
    if ({cmd, cpu_stall} !== 2'b00) begin
      $display("FAIL b2b_idle: got %b expected 00", {cmd, cpu_stall});
      n_fail++;
    end
    tick();
    n_checks++;
    if (cmd !== 1'b1) begin
      $display("FAIL b2b_second_cmd: got %b expected 1", cmd);
      n_fail++;
    end
    BR = 1'b1;
    tick();
    tick();
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    BR      = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cmd !== 1'b0) begin
        $display("FAIL b2b_no_third: cycle %0d got %b expected 0", i, cmd);
        n_fail++;
      end
    end
    n_checks++;
    if (xfer_count !== 8'd2) begin
      $display("FAIL b2b_count: got %0d expected 2", xfer_count);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    BR        = 1'b1;
    tick();
    tick();
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    BR      = 1'b0;
    tick();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    BR        = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({BG, xfer_count} !== {1'b1, 8'd1}) begin
      $display("FAIL rst_pre_grant: got %b/%0d expected 1/1", BG, xfer_count);
      n_fail++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd, BG, cpu_stall, timeout_err, xfer_count} !== {4'b0000, 8'd0}) begin
      $display("FAIL rst_async: got %b/%0d expected 0000/0", {cmd, BG, cpu_stall, timeout_err}, xfer_count);
      n_fail++;
    end
    BR = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({cmd, BG, cpu_stall} !== 3'b000) begin
      $display("FAIL rst_idle_after: got %b expected 000", {cmd, BG, cpu_stall});
      n_fail++;
    end
  endtask

  task automatic test_wrap_stray();
    do_reset();
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    n_checks++;
    if ({cmd, cpu_stall, xfer_count} !== {2'b00, 8'd0}) begin
      $display("FAIL stray_end_idle: got %b/%0d expected 00/0", {cmd, cpu_stall}, xfer_count);
      n_fail++;
    end
    for (int t = 1; t <= 256; t++) begin
      dma_begin = 1'b1;
      tick();
      dma_begin = 1'b0;
      dma_end   = 1'b1;
      BR        = 1'b1;
      tick();
      dma_end = 1'b0;
      tick();
      dma_end = 1'b1;
      tick();
      dma_end = 1'b0;
      BR      = 1'b0;
      tick();
      if (t == 1 || t == 255) begin
        n_checks++;
        if (xfer_count !== 8'(t)) begin
          $display("FAIL wrap_count_%0d: got %0d expected %0d", t, xfer_count, t);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (xfer_count !== 8'd0) begin
      $display("FAIL wrap_count_256: got %0d expected 0", xfer_count);
      n_fail++;
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    dma_begin = 1'b1;
    tick();
    dma_begin = 1'b0;
    BR        = 1'b1;
    tick();
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      n_checks++;
      if ({BG, timeout_err} !== 2'b10) begin
        $display("FAIL wd_grant_hold: cycle %0d got %b expected 10", i, {BG, timeout_err});
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if ({BG, cmd, timeout_err, xfer_count} !== {3'b001, 8'd0}) begin
      $display("FAIL wd_abort: got %b/%0d expected 001/0", {BG, cmd, timeout_err}, xfer_count);
      n_fail++;
    end
    tick();
    n_checks++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL wd_pulse_width: got %b expected 0", timeout_err);
      n_fail++;
    end
    BR = 1'b0;
    tick();
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
    end
    n_checks++;
    if ({BG, timeout_err, xfer_count} !== {2'b10, 8'd0}) begin
      $display("FAIL no_wd_hold: got %b/%0d expected 10/0", {BG, timeout_err}, xfer_count);
      n_fail++;
    end
    dma_end = 1'b1;
    tick();
    dma_end = 1'b0;
    BR      = 1'b0;
    tick();
    n_checks++;
    if ({BG, xfer_count} !== {1'b0, 8'd1}) begin
      $display("FAIL no_wd_finish: got %b/%0d expected 0/1", BG, xfer_count);
      n_fail++;
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_cpu_busy();
    test_back_to_back();
    test_reset_mid_grant();
    test_wrap_stray();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
